// File: rtl/sap1_controlador_sequenciador.sv
// SAP-1 control sequencer: six-state ring counter plus
// control-word decoder with run/step/halt handling.
module sap1_controlador_sequenciador #(
   parameter logic [3:0] OP_LDA    = 4'b0000,
   parameter logic [3:0] OP_ADD    = 4'b0001,
   parameter logic [3:0] OP_SUB    = 4'b0010,
   parameter logic [3:0] OP_OUT    = 4'b1110,
   parameter logic [3:0] OP_HLT    = 4'b1111,
   parameter bit         EARLY_END = 1'b0
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       run,
   input  logic       step,
   input  logic [3:0] opcode,
   output logic       PC_INC,
   output logic       PC_OUT,
   output logic       MAR_IN,
   output logic       RAM_OUT,
   output logic       IR_IN,
   output logic       IR_OUT,
   output logic       ACC_IN,
   output logic       ACC_OUT,
   output logic       SUB,
   output logic       ALU_OUT,
   output logic       B_IN,
   output logic       OPR_IN,
   output logic       HALT,
   output logic [5:0] t_state,
   output logic [7:0] instr_count
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } ring_e;

   ring_e      ring;
   ring_e      ring_nxt;
   logic       halted;
   logic [7:0] count;
   logic       step_d;
   logic       step_pulse;
   logic       adv;
   logic       is_lda;
   logic       is_add;
   logic       is_sub;
   logic       is_out;
   logic       is_hlt;
   logic       is_nop;
   logic       last;

   assign is_lda = (opcode == OP_LDA);
   assign is_add = (opcode == OP_ADD);
   assign is_sub = (opcode == OP_SUB);
   assign is_out = (opcode == OP_OUT);
   assign is_hlt = (opcode == OP_HLT);
   assign is_nop = ~(is_lda | is_add | is_sub
                     | is_out | is_hlt);

   assign step_pulse = step & ~step_d;
   // clear in the term drops every strobe while reset is held
   assign adv = clear & ~halted & (run | step_pulse);

   // final T-state of the current instruction
   assign last = (ring == T6)
               | (EARLY_END && (ring == T4)
                  && (is_out | is_nop))
               | (EARLY_END && (ring == T5) && is_lda);

   assign ring_nxt = ring_e'({ring[4:0], ring[5]});

   assign t_state     = ring;
   assign HALT        = halted;
   assign instr_count = count;

   // ring advance, halt latch, step edge detect, counter
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ring   <= T1;
         halted <= 1'b0;
         count  <= 8'd0;
         step_d <= 1'b0;
      end else begin
         step_d <= step;
         if (adv) begin
            if ((ring == T4) && is_hlt) begin
               halted <= 1'b1;
               count  <= count + 8'd1;
            end else if (last) begin
               ring  <= T1;
               count <= count + 8'd1;
            end else begin
               ring <= ring_nxt;
            end
         end
      end
   end

   // control word, gated so loads happen only on advancing edges
   always_comb begin
      PC_INC  = 1'b0;
      PC_OUT  = 1'b0;
      MAR_IN  = 1'b0;
      RAM_OUT = 1'b0;
      IR_IN   = 1'b0;
      IR_OUT  = 1'b0;
      ACC_IN  = 1'b0;
      ACC_OUT = 1'b0;
      SUB     = 1'b0;
      ALU_OUT = 1'b0;
      B_IN    = 1'b0;
      OPR_IN  = 1'b0;
      if (adv) begin
         unique case (ring)
            T1: begin
               PC_OUT = 1'b1;
               MAR_IN = 1'b1;
            end
            T2: PC_INC = 1'b1;
            T3: begin
               RAM_OUT = 1'b1;
               IR_IN   = 1'b1;
            end
            T4: begin
               if (is_lda | is_add | is_sub) begin
                  IR_OUT = 1'b1;
                  MAR_IN = 1'b1;
               end
               if (is_out) begin
                  ACC_OUT = 1'b1;
                  OPR_IN  = 1'b1;
               end
            end
            T5: begin
               if (is_lda) begin
                  RAM_OUT = 1'b1;
                  ACC_IN  = 1'b1;
               end
               if (is_add | is_sub) begin
                  RAM_OUT = 1'b1;
                  B_IN    = 1'b1;
               end
            end
            T6: begin
               if (is_add | is_sub) begin
                  ALU_OUT = 1'b1;
                  ACC_IN  = 1'b1;
                  SUB     = is_sub;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
